// File: rtl/dn_route_cfg_loader_if.sv
// Benes route-config stream and network-control bundle.
// master: configuration source; slave: the loader.
interface dn_route_cfg_loader_if #(
    parameter int N           = 64,
    parameter int SW_PER_BEAT = 16
);
    localparam int N_LEVELS = 2 * $clog2(N) - 1;
    localparam int N_SW     = N_LEVELS * N / 2;

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [2*SW_PER_BEAT-1:0] cfg_data;
    logic                     cfg_last;
    logic                     cfg_err;
    logic                     cfg_loaded;
    logic                     run_req;
    logic                     stop_req;
    logic [2*N_SW-1:0]        route_signals;
    logic                     set_en;
    logic                     route_en;

    modport master (
        output cfg_valid, cfg_data, cfg_last, run_req, stop_req,
        input  cfg_ready, cfg_err, cfg_loaded, route_signals,
        input  set_en, route_en
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, run_req, stop_req,
        output cfg_ready, cfg_err, cfg_loaded, route_signals,
        output set_en, route_en
    );
endinterface

// File: rtl/dn_route_cfg_loader.sv
// Double-buffered Benes switch-setting loader: fills a shadow bank
// from a beat stream, commits it to the active bank, sequences set/route.
module dn_route_cfg_loader #(
    parameter int N           = 64,
    parameter int SW_PER_BEAT = 16
) (
    input logic            clk,
    input logic            reset,
    dn_route_cfg_loader_if.slave cfg
);
    localparam int N_LEVELS = 2 * $clog2(N) - 1;
    localparam int N_SW     = N_LEVELS * N / 2;
    localparam int W        = 2 * SW_PER_BEAT;
    localparam int N_BEATS  = (N_SW + SW_PER_BEAT - 1) / SW_PER_BEAT;
    localparam int BW       = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);

    typedef enum logic {
        FILL,
        FULL
    } state_e;

    state_e              state_q;
    logic [BW-1:0]       beat_cnt_q;
    logic [BW-1:0]       beat_cnt_d;
    logic [W-1:0]        shadow_q [N_BEATS];
    logic [2*N_SW-1:0]   active_q;
    logic                ready_q;
    logic                err_q;
    logic                loaded_q;
    logic                set_en_q;
    logic                route_en_q;

    logic [N_BEATS*W-1:0] shadow_flat;
    logic                 accept;
    logic                 commit;
    logic                 final_beat;

    assign accept     = cfg.cfg_valid & ready_q;
    assign commit     = (state_q == FULL) & cfg.run_req;
    assign final_beat = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        shadow_flat = '0;
        for (int b = 0; b < N_BEATS; b++) begin
            shadow_flat[b*W +: W] = shadow_q[b];
        end
    end

    // Both a good and a malformed end of frame restart at beat 0.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            if (final_beat || cfg.cfg_last) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            beat_cnt_q <= '0;
            active_q   <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            loaded_q   <= 1'b0;
            set_en_q   <= 1'b0;
            route_en_q <= 1'b0;
            for (int b = 0; b < N_BEATS; b++) begin
                shadow_q[b] <= '0;
            end
        end else begin
            err_q      <= 1'b0;
            set_en_q   <= 1'b0;
            beat_cnt_q <= beat_cnt_d;
            if (accept) begin
                shadow_q[beat_cnt_q] <= cfg.cfg_data;
            end
            unique case (state_q)
                FILL: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (final_beat && cfg.cfg_last) begin
                            state_q  <= FULL;
                            ready_q  <= 1'b0;
                            loaded_q <= 1'b1;
                        end else if (final_beat || cfg.cfg_last) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (cfg.run_req) begin
                        active_q <= shadow_flat[2*N_SW-1:0];
                        loaded_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= FILL;
                    end
                end
            endcase
            // Commit outranks stop; routing resumes one cycle after the latch strobe.
            if (commit) begin
                set_en_q   <= 1'b1;
                route_en_q <= 1'b0;
            end else if (cfg.stop_req) begin
                route_en_q <= 1'b0;
            end else if (set_en_q) begin
                route_en_q <= 1'b1;
            end
        end
    end

    assign cfg.cfg_ready     = ready_q;
    assign cfg.cfg_err       = err_q;
    assign cfg.cfg_loaded    = loaded_q;
    assign cfg.route_signals = active_q;
    assign cfg.set_en        = set_en_q;
    assign cfg.route_en      = route_en_q;
endmodule
